// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode path: opcodes, one-hot type
// indices and immediate formats.
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int NUM_TYPES = 11;

    typedef enum logic [3:0] {
        T_LUI      = 4'd0,
        T_AUIPC    = 4'd1,
        T_JAL      = 4'd2,
        T_JALR     = 4'd3,
        T_BRANCH   = 4'd4,
        T_LOAD     = 4'd5,
        T_STORE    = 4'd6,
        T_OP_IMM   = 4'd7,
        T_OP       = 4'd8,
        T_MISC_MEM = 4'd9,
        T_SYSTEM   = 4'd10
    } type_idx_e;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the RISC-V immediate for the
// given format and sign-extends it from instr[31] to XLEN bits.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Upper bits beyond 32 only exist for XLEN=64; they copy the sign.
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked instruction decode stage with optional skid buffer
// and a saturating counter of accepted illegal instructions.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [10:0]       type_o,
    output logic              illegal_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [CNT_W-1:0]  illegal_cnt_o
);

    typedef struct packed {
        logic [NUM_TYPES-1:0] typ;
        logic                 illegal;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
    } dec_t;

    logic [NUM_TYPES-1:0] type_vec;
    logic                 is_illegal;
    imm_fmt_e             fmt;
    logic [XLEN-1:0]      imm_raw;
    dec_t                 dec;

    dec_t                 out_q, out_d, skid_q, skid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 ready_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_fire;

    always_comb begin
        type_vec   = '0;
        is_illegal = 1'b0;
        fmt        = FMT_NONE;
        case (instr_i[6:0])
            OPC_LUI:      begin type_vec[T_LUI]      = 1'b1; fmt = FMT_U; end
            OPC_AUIPC:    begin type_vec[T_AUIPC]    = 1'b1; fmt = FMT_U; end
            OPC_JAL:      begin type_vec[T_JAL]      = 1'b1; fmt = FMT_J; end
            OPC_JALR:     begin type_vec[T_JALR]     = 1'b1; fmt = FMT_I; end
            OPC_BRANCH:   begin type_vec[T_BRANCH]   = 1'b1; fmt = FMT_B; end
            OPC_LOAD:     begin type_vec[T_LOAD]     = 1'b1; fmt = FMT_I; end
            OPC_STORE:    begin type_vec[T_STORE]    = 1'b1; fmt = FMT_S; end
            OPC_OP_IMM:   begin type_vec[T_OP_IMM]   = 1'b1; fmt = FMT_I; end
            OPC_OP:       begin type_vec[T_OP]       = 1'b1; fmt = FMT_NONE; end
            OPC_MISC_MEM: begin type_vec[T_MISC_MEM] = 1'b1; fmt = FMT_I; end
            OPC_SYSTEM:   begin type_vec[T_SYSTEM]   = 1'b1; fmt = FMT_I; end
            // Any opcode with instr[1:0] != 2'b11 also lands here.
            default:      is_illegal = 1'b1;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_i),
        .fmt   (fmt),
        .imm   (imm_raw)
    );

    always_comb begin
        dec         = '0;
        dec.typ     = type_vec;
        dec.illegal = is_illegal;
        dec.rd      = instr_i[11:7];
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.funct3  = instr_i[14:12];
        dec.funct7  = instr_i[31:25];
        dec.imm     = imm_raw;
        dec.pc      = pc_i;
    end

    assign ready_o = SKID_EN ? ready_q : (!out_valid_q || ready_i);
    assign in_fire = valid_i && ready_o && !flush_i;

    // Output register is refilled from the skid first so order is preserved;
    // new words bypass the skid whenever the output is free or draining.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_valid_q && !ready_i) begin
            if (SKID_EN && in_fire) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (in_fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= !skid_valid_d;
            if (in_fire && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign valid_o       = out_valid_q;
    assign type_o        = out_q.typ;
    assign illegal_o     = out_q.illegal;
    assign rd_o          = out_q.rd;
    assign rs1_o         = out_q.rs1;
    assign rs2_o         = out_q.rs2;
    assign funct3_o      = out_q.funct3;
    assign funct7_o      = out_q.funct7;
    assign imm_o         = out_q.imm;
    assign pc_o          = out_q.pc;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors plus
// directed backpressure, saturation, flush and reset sequences.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    localparam logic [31:0] ADDI = 32'h00500093;

    logic             clk;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [XLEN-1:0]  pc_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [10:0]      type_o;
    logic             illegal_o;
    logic [4:0]       rd_o, rs1_o, rs2_o;
    logic [2:0]       funct3_o;
    logic [6:0]       funct7_o;
    logic [XLEN-1:0]  imm_o;
    logic [XLEN-1:0]  pc_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    int checks = 0;
    int fails  = 0;

    decode_stage #(.XLEN(XLEN), .SKID_EN(1'b1), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .type_o        (type_o),
        .illegal_o     (illegal_o),
        .rd_o          (rd_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .funct3_o      (funct3_o),
        .funct7_o      (funct7_o),
        .imm_o         (imm_o),
        .pc_o          (pc_o),
        .illegal_cnt_o (illegal_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] typ;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[13];

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                 input logic [XLEN-1:0] pc, input logic rdy,
                                 input logic fl, input logic rs);
        valid_i = v;
        instr_i = ins;
        pc_i    = pc;
        ready_i = rdy;
        flush_i = fl;
        rst_i   = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int expCnt;

        vecs[0]  = '{32'h00500093, 11'h080, 1'b0, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005};
        vecs[1]  = '{32'h123450B7, 11'h001, 1'b0, 5'd1,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000};
        vecs[2]  = '{32'hFE000EE3, 11'h010, 1'b0, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC};
        vecs[3]  = '{32'h0020A423, 11'h040, 1'b0, 5'd8,  5'd1,  5'd2,  3'd2, 7'h00, 32'h00000008};
        vecs[4]  = '{32'hFFDFF0EF, 11'h004, 1'b0, 5'd1,  5'd31, 5'd29, 3'd7, 7'h7F, 32'hFFFFFFFC};
        vecs[5]  = '{32'h002081B3, 11'h100, 1'b0, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000};
        vecs[6]  = '{32'hFFFFFFFF, 11'h000, 1'b1, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000};
        vecs[7]  = '{32'hFFF12283, 11'h020, 1'b0, 5'd5,  5'd2,  5'd31, 3'd2, 7'h7F, 32'hFFFFFFFF};
        vecs[8]  = '{32'h00500091, 11'h000, 1'b1, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000000};
        vecs[9]  = '{32'h00001017, 11'h002, 1'b0, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, 32'h00001000};
        vecs[10] = '{32'h0000000F, 11'h200, 1'b0, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000};
        vecs[11] = '{32'h00008067, 11'h008, 1'b0, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h00000000};
        vecs[12] = '{32'h00000073, 11'h400, 1'b0, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000};

        applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset valid_o", valid_o, 0);
        checkOutput("reset ready_o", ready_o, 1);
        checkOutput("reset cnt", illegal_cnt_o, 0);
        checkOutput("reset type_o", type_o, 0);
        checkOutput("reset imm_o", imm_o, 0);
        checkOutput("reset pc_o", pc_o, 0);

        $display("[TB] decode table");
        expCnt = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            if (vecs[i].illegal && expCnt < 3) expCnt++;
            checkOutput($sformatf("v%0d valid", i),   valid_o,       1);
            checkOutput($sformatf("v%0d type", i),    type_o,        vecs[i].typ);
            checkOutput($sformatf("v%0d illegal", i), illegal_o,     vecs[i].illegal);
            checkOutput($sformatf("v%0d rd", i),      rd_o,          vecs[i].rd);
            checkOutput($sformatf("v%0d rs1", i),     rs1_o,         vecs[i].rs1);
            checkOutput($sformatf("v%0d rs2", i),     rs2_o,         vecs[i].rs2);
            checkOutput($sformatf("v%0d funct3", i),  funct3_o,      vecs[i].f3);
            checkOutput($sformatf("v%0d funct7", i),  funct7_o,      vecs[i].f7);
            checkOutput($sformatf("v%0d imm", i),     imm_o,         vecs[i].imm);
            checkOutput($sformatf("v%0d pc", i),      pc_o,          32'h1000 + 32'(i * 4));
            checkOutput($sformatf("v%0d cnt", i),     illegal_cnt_o, expCnt);
        end
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain valid_o", valid_o, 0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp1 valid_o", valid_o, 1);
        checkOutput("bp1 pc_o", pc_o, 32'h0);
        checkOutput("bp1 ready_o", ready_o, 1);
        applyStimulus(1'b1, ADDI, 32'h4, 1'b0, 1'b0, 1'b0);
        checkOutput("bp2 pc_o", pc_o, 32'h0);
        checkOutput("bp2 ready_o", ready_o, 0);
        applyStimulus(1'b1, ADDI, 32'h8, 1'b0, 1'b0, 1'b0);
        checkOutput("bp3 valid_o", valid_o, 1);
        checkOutput("bp3 pc_o", pc_o, 32'h0);
        checkOutput("bp3 ready_o", ready_o, 0);
        applyStimulus(1'b1, ADDI, 32'h8, 1'b1, 1'b0, 1'b0);
        checkOutput("bp4 valid_o", valid_o, 1);
        checkOutput("bp4 pc_o", pc_o, 32'h4);
        checkOutput("bp4 ready_o", ready_o, 1);
        applyStimulus(1'b1, ADDI, 32'h8, 1'b1, 1'b0, 1'b0);
        checkOutput("bp5 valid_o", valid_o, 1);
        checkOutput("bp5 pc_o", pc_o, 32'h8);
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp6 valid_o", valid_o, 0);

        $display("[TB] illegal saturation");
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("sat reset cnt", illegal_cnt_o, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 32'h0, 32'h200 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("sat%0d valid", k),   valid_o,       1);
            checkOutput($sformatf("sat%0d illegal", k), illegal_o,     1);
            checkOutput($sformatf("sat%0d type", k),    type_o,        0);
            checkOutput($sformatf("sat%0d imm", k),     imm_o,         0);
            checkOutput($sformatf("sat%0d cnt", k),     illegal_cnt_o, (k < 3) ? k : 3);
        end

        $display("[TB] flush");
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0);
        checkOutput("fl cnt before", illegal_cnt_o, 1);
        applyStimulus(1'b1, ADDI, 32'h14, 1'b0, 1'b0, 1'b0);
        checkOutput("fl full ready_o", ready_o, 0);
        applyStimulus(1'b1, 32'h0, 32'h18, 1'b0, 1'b1, 1'b0);
        checkOutput("fl valid_o", valid_o, 0);
        checkOutput("fl ready_o", ready_o, 1);
        checkOutput("fl cnt", illegal_cnt_o, 1);
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl after valid_o", valid_o, 0);
        applyStimulus(1'b1, ADDI, 32'h20, 1'b0, 1'b0, 1'b0);
        checkOutput("fl2 pre ready_o", ready_o, 1);
        applyStimulus(1'b1, 32'h0, 32'h24, 1'b0, 1'b1, 1'b0);
        checkOutput("fl2 valid_o", valid_o, 0);
        checkOutput("fl2 cnt", illegal_cnt_o, 1);
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl2 after valid_o", valid_o, 0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h0, 32'h30, 1'b0, 1'b0, 1'b0);
        checkOutput("rs cnt before", illegal_cnt_o, 2);
        applyStimulus(1'b1, ADDI, 32'h34, 1'b0, 1'b0, 1'b0);
        checkOutput("rs full ready_o", ready_o, 0);
        applyStimulus(1'b1, 32'h0, 32'h38, 1'b0, 1'b0, 1'b1);
        checkOutput("rs valid_o", valid_o, 0);
        checkOutput("rs ready_o", ready_o, 1);
        checkOutput("rs cnt", illegal_cnt_o, 0);
        checkOutput("rs pc_o", pc_o, 0);
        checkOutput("rs type_o", type_o, 0);
        applyStimulus(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("rs after valid_o", valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I/RV64I instruction decode stage that replaces the purely combinational opcode-type decoder.
- Sits between the fetch and execute stages.
- Classifies the opcode into a one-hot type vector, extracts register fields and generates the sign-extended immediate.
- Flags illegal encodings and counts them, with a skid buffer so fetch sees a registered ready.

Parameters:
- XLEN, 32, datapath width of immediate and PC (32 or 64).
- SKID_EN, 1, 1 = two-entry buffering (output reg + skid reg) with registered ready_o; 0 = single output register, ready_o = !valid_o || ready_i.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  fetch has an instruction
- ready_o  out  1  stage can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- flush_i  in  1  discard all held and incoming instructions
- valid_o  out  1  decoded instruction available
- ready_i  in  1  execute accepts
- type_o  out  11  one-hot type: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]OP_IMM [8]OP [9]MISC_MEM [10]SYSTEM
- illegal_o  out  1  instruction is illegal
- rd_o, rs1_o, rs2_o  out  5 each  register fields
- funct3_o  out  3  instr[14:12]
- funct7_o  out  7  instr[31:25]
- imm_o  out  XLEN  sign-extended immediate
- pc_o  out  XLEN  PC of the decoded instruction
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset: valid_o=0, skid empty, ready_o=1, illegal_cnt_o=0, all data outputs 0.
- Input transfer when valid_i && ready_o. Output transfer when valid_o && ready_i.
- Latency: 1 cycle from input transfer to valid_o, when the output register is free.
- Opcode decode (instr[6:0]):
  - 0110111 LUI; 0010111 AUIPC; 1101111 JAL; 1100111 JALR; 1100011 BRANCH
  - 0000011 LOAD; 0100011 STORE; 0010011 OP_IMM; 0110011 OP; 0001111 MISC_MEM; 1110011 SYSTEM
- Illegal: instr[1:0] != 2'b11, or opcode not in the list above. Then type_o=0, imm_o=0, illegal_o=1; field outputs still carry the raw bits.
- Immediate formats, all sign-extended from instr[31] to XLEN:
  - I format (JALR, LOAD, OP_IMM, SYSTEM, MISC_MEM)
  - S format (STORE)
  - B format (BRANCH)
  - U format (LUI, AUIPC), value is {instr[31:12], 12'b0}
  - J format (JAL)
  - OP: imm_o=0.
- Decode is combinational on instr_i; results are registered at input transfer. Outputs are held stable while valid_o && !ready_i.
- SKID_EN=1:
  - If the output register is occupied and not draining, an accepted word goes to the skid register.
  - ready_o is registered: ready_o = !skid_valid.
  - When the output drains and the skid is full, the skid word moves to the output next cycle.
  - Simultaneous drain of output and accept of input with the skid empty: the new word goes directly to the output register.
  - Order is always preserved.
- SKID_EN=0: ready_o = !valid_o || ready_i. Same-cycle drain and accept is allowed.
- flush_i: next cycle valid_o=0 and skid empty. An input offered during flush is dropped and not counted. ready_o=1 the cycle after flush.
- Counter: increments by 1 on each input transfer of an illegal instruction (not flushed). Saturates at all-ones with no wrap.
- Reset mid-operation: same as the reset state; all held instructions are lost.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams
  - type-index enum (11 entries)
  - immediate-format enum (I, S, B, U, J, NONE)
- Sub-module imm_gen: purely combinational, (instr, format) -> XLEN immediate. It is reused by the compressed-decode path later.
- The handshake/skid logic stays in decode_stage.

Test Plan:
- Basic decode: 0x00500093 (addi x1,x0,5), ready_i=1 -> next cycle valid_o=1, type_o[7]=1, rd_o=1, rs1_o=0, imm_o=5.
- LUI: 0x123450B7 -> type_o[0]=1, rd_o=1, imm_o=0x12345000.
- Branch: 0xFE000EE3 (beq x0,x0,-4) -> type_o[4]=1, imm_o=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
- Backpressure: ready_i=0 with valid_i=1 on PC 0x0, 0x4, 0x8:
  - 0x0 goes to output, 0x4 to skid, ready_o falls; 0x8 is held off.
  - Raise ready_i -> 0x0, 0x4, 0x8 appear on consecutive cycles, in order, with no loss or duplication.
- Illegal/saturation (CNT_W=2): five transfers of 0x00000000 -> each has illegal_o=1, type_o=0; illegal_cnt_o goes 1,2,3,3,3.
- Flush/reset: output and skid both full; assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, the offered word is never output and the counter is unchanged. Repeat with rst_i -> illegal_cnt_o=0.
